mdu_sched: RTL
==============

MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of mult/multu, in cycles (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of div/divu, in cycles (legal range 1..15).
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port op_d, input, 4: MD op code of the instruction in the D stage.
REQ-006 Port op_e, input, 4: MD op code of the instruction in the E stage.
REQ-007 Port data1, input, 32: forwarded rs value in the E stage.
REQ-008 Port data2, input, 32: forwarded rt value in the E stage.
REQ-009 Port busy, output, 1: a multiply or divide is in flight.
REQ-010 Port stall_md, output, 1: request to stall the D stage.
REQ-011 Port hi, output, 32: architectural HI register.
REQ-012 Port lo, output, 32: architectural LO register.
REQ-013 Port out, output, 32: mfhi/mflo read data.

Function
REQ-014 Op codes SHALL be: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; codes 9..15 are treated as none.
REQ-015 FSM SHALL have states IDLE and BUSY; busy = (state == BUSY).
REQ-016 In IDLE with op_e in 1..4 at an edge, the block SHALL latch the result, load a 4-bit counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-017 In BUSY the counter SHALL decrement every edge; at the edge where the counter equals 1 the block SHALL commit the latched result to HI/LO and return to IDLE, so busy is high for exactly N cycles.
REQ-018 mult/multu SHALL yield the 64-bit signed/unsigned product, with {hi,lo} = product.
REQ-019 div/divu SHALL yield lo = quotient truncated toward zero and hi = remainder taking the sign of the dividend; for signed 0x80000000 / 0xFFFFFFFF the result is lo = 0x80000000, hi = 0.
REQ-020 An op_e of mthi/mtlo in IDLE SHALL write data1 into HI/LO at that edge.
REQ-021 An op_e in 1..8 arriving while in BUSY SHALL be ignored and leave the counter, the pending result and HI/LO unchanged; this is a protocol violation and the bench asserts on it.
REQ-022 stall_md SHALL be combinational: (busy OR op_e in 1..4) AND op_d in 1..8.
REQ-023 out SHALL be combinational: hi when op_e = 5, lo when op_e = 6, else 0.
REQ-024 HI/LO SHALL never show a partial or intermediate value; they change only at a commit or an mthi/mtlo edge.

Reset
REQ-025 Reset SHALL set state to IDLE, counter, hi and lo to 0, and the pending result to 0.
REQ-026 Reset asserted in BUSY SHALL abort the operation with no commit; busy is 0 in the cycle after the reset edge.
REQ-027 Reset has priority over every other event at the same edge, including a commit.

Configuration
REQ-028 With macro MDU_DIV0_HOLD_EN defined, div/divu with data2 = 0 SHALL still be busy for DIV_CYCLES and then leave HI/LO unchanged at the commit edge.
REQ-029 Without MDU_DIV0_HOLD_EN, div/divu with data2 = 0 SHALL commit lo = 0xFFFFFFFF and hi = data1.

Verification
REQ-030 Scenario mult: data1 = 0xFFFFFFFF, data2 = 2, op_e = 1 for one cycle -> busy high for 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE; multu with the same operands -> hi = 1, lo = 0xFFFFFFFE.
REQ-031 Scenario div: data1 = -7, data2 = 2, op_e = 3 -> busy high for 10 cycles, then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; hi/lo hold their old values until the 10th edge.
REQ-032 Scenario stall: op_d = 6 with mult started -> stall_md = 1 in the start cycle and for all 5 busy cycles, then 0; op_d = 0 -> stall_md stays 0.
REQ-033 Scenario move/read: op_e = 7, data1 = 0x12345678 -> hi = 0x12345678 next cycle; op_e = 5 then gives out = 0x12345678.
REQ-034 Scenario abort: div started, reset pulsed at busy cycle 4 -> busy = 0 next cycle, hi = lo = 0, no later commit.
REQ-035 Scenario divide-by-zero: data1 = 5, data2 = 0, op_e = 4, run once with and once without MDU_DIV0_HOLD_EN -> HI/LO held, versus lo = 0xFFFFFFFF and hi = 5.

Source files
------------

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle mult/div scheduler with HI/LO, D-stage stall and mfhi/mflo read.
// Define MDU_DIV0_HOLD_EN to leave HI/LO untouched by a divide by zero.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op_d,
  input  logic [3:0]  op_e,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);
`ifdef MDU_DIV0_HOLD_EN
  localparam logic DIV0_HOLD = 1'b1;
`else
  localparam logic DIV0_HOLD = 1'b0;
`endif
  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rhi_q, rhi_d;
  logic [31:0] rlo_q, rlo_d;
  logic        hold_q, hold_d;

  logic        is_mul, is_div, is_sgn;
  logic        op_d_md, div0;
  logic [63:0] ext1, ext2, prod;
  logic [31:0] mag1, mag2;
  logic [31:0] q_u, r_u, q_s, r_s;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    is_sgn = 1'b0;
    unique case (op_e)
      4'd1: begin is_mul = 1'b1; is_sgn = 1'b1; end
      4'd2: is_mul = 1'b1;
      4'd3: begin is_div = 1'b1; is_sgn = 1'b1; end
      4'd4: is_div = 1'b1;
      default: ;
    endcase
  end

  // Divide on magnitudes so the most-negative / -1 case wraps cleanly
  always_comb begin
    ext1 = is_sgn ? {{32{data1[31]}}, data1} : {32'd0, data1};
    ext2 = is_sgn ? {{32{data2[31]}}, data2} : {32'd0, data2};
    prod = ext1 * ext2;
    mag1 = (is_sgn && data1[31]) ? -data1 : data1;
    mag2 = (is_sgn && data2[31]) ? -data2 : data2;
    div0 = (data2 == 32'd0);
    q_u  = div0 ? 32'd0 : mag1 / mag2;
    r_u  = div0 ? 32'd0 : mag1 % mag2;
    q_s  = (is_sgn && (data1[31] ^ data2[31])) ? -q_u : q_u;
    r_s  = (is_sgn && data1[31]) ? -r_u : r_u;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (is_mul || is_div) begin
          state_d = BUSY;
          cnt_d   = is_mul ? MUL_N : DIV_N;
          hold_d  = 1'b0;
          if (is_mul) begin
            rhi_d = prod[63:32];
            rlo_d = prod[31:0];
          end else if (div0) begin
            rhi_d  = data1;
            rlo_d  = 32'hFFFF_FFFF;
            hold_d = DIV0_HOLD;
          end else begin
            rhi_d = r_s;
            rlo_d = q_s;
          end
        end else if (op_e == 4'd7) begin
          hi_d = data1;
        end else if (op_e == 4'd8) begin
          lo_d = data1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (!hold_q) begin
            hi_d = rhi_q;
            lo_d = rlo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rhi_q   <= 32'd0;
      rlo_q   <= 32'd0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      hold_q  <= hold_d;
    end
  end

  assign op_d_md  = (op_d != 4'd0) && (op_d <= 4'd8);
  assign busy     = (state_q == BUSY);
  assign stall_md = (busy || is_mul || is_div) && op_d_md;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign out      = (op_e == 4'd5) ? hi_q :
                    (op_e == 4'd6) ? lo_q : 32'd0;

endmodule
